// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction prefetcher feeding the core.
// Fetches 32-bit words into a DEPTH-entry circular queue of {addr, data},
// presents the head word to the control unit, and handles PC redirects by
// flushing the queue and dropping any response still in flight.
// Optional macro FETCH_STATS_EN adds saturating fetch_count/discard_count
// outputs; without it those ports and counters do not exist.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  input  logic        inst_req,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] inst_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] discard_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_disc_addr;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_q_addr [DEPTH];
  logic [31:0]     r_q_data [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_next;

  // A redirect outranks both the pop and the push on the same edge.
  assign w_push       = (r_state == S_REQ) && mem_ack && !pc_load;
  assign w_pop        = inst_req && (r_count != '0) && !pc_load;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // Head-of-queue presentation; forced to zero while empty.
  assign inst_valid  = (r_count != '0);
  assign instruction = inst_valid ? r_q_data[r_head] : 32'h0;
  assign inst_addr   = inst_valid ? r_q_addr[r_head] : 32'h0;

  // Memory request from registered state only; DISCARD keeps the old address.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = 32'h0;
    case (r_state)
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_fetch_pc;
      end
      S_DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = r_disc_addr;
      end
      default: begin
        mem_req  = 1'b0;
        mem_addr = 32'h0;
      end
    endcase
  end

  // Next-state logic for the fetch FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A redirect empties the queue, so space is guaranteed.
        if (pc_load || (r_count < CW'(DEPTH)))
          w_state_next = S_REQ;
      end
      S_REQ: begin
        if (pc_load)
          w_state_next = mem_ack ? S_REQ : S_DISCARD;
        else if (mem_ack)
          w_state_next = (w_count_next < CW'(DEPTH)) ? S_REQ : S_IDLE;
      end
      S_DISCARD: begin
        // The stale response completes the old request; resume at fetch_pc.
        if (mem_ack)
          w_state_next = S_REQ;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state, fetch PC and the address held for a pending discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_disc_addr <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (pc_load)
        r_fetch_pc <= pc_target;
      else if (w_push)
        r_fetch_pc <= r_fetch_pc + 32'(PC_STEP);
      if ((r_state == S_REQ) && pc_load && !mem_ack)
        r_disc_addr <= r_fetch_pc;
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (pc_load) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + AW'(1);
      if (w_pop)
        r_head <= r_head + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Queue storage; contents are don't-care while their slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= r_fetch_pc;
      r_q_data[r_tail] <= mem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  logic w_ack;
  logic w_drop;
  logic [15:0] r_fetch_count;
  logic [15:0] r_discard_count;

  assign w_ack  = mem_req && mem_ack;
  assign w_drop = w_ack && ((r_state == S_DISCARD) || pc_load);

  // Saturating counters of accepted and dropped responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count   <= 16'h0;
      r_discard_count <= 16'h0;
    end else begin
      if (w_ack && (r_fetch_count != 16'hFFFF))
        r_fetch_count <= r_fetch_count + 16'h1;
      if (w_drop && (r_discard_count != 16'hFFFF))
        r_discard_count <= r_discard_count + 16'h1;
    end
  end

  assign fetch_count   = r_fetch_count;
  assign discard_count = r_discard_count;
`endif

endmodule
